// File: rtl/divider_pkg.sv
// Control encodings shared by the shift-subtract divider and shift-add multiplier.
// Also provides a constant-foldable clog2 for counter sizing.
package divider_pkg;

  typedef enum logic [1:0] {
    StIdle = 2'b00,
    StRun  = 2'b01,
    StDone = 2'b10
  } div_state_e;

  // Never returns 0, so a counter for value==1 still has one bit.
  function automatic int unsigned clog2(input int unsigned value);
    int unsigned result;
    result = 1;
    for (int i = 1; i < 32; i++) begin
      if ((32'd1 << i) < value) result = i + 1;
    end
    return result;
  endfunction

endpackage

// File: rtl/mul_shift_add_dp.sv
// Shift-add multiplier datapath: accumulator, shifting multiplicand and multiplier.
// Control (load/step) comes from the top-level FSM.
module mul_shift_add_dp
  import divider_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic               CLK,
  input  logic               CLR_bar,
  input  logic               i_load,
  input  logic               i_step,
  input  logic [WIDTH-1:0]   i_a,
  input  logic [WIDTH-1:0]   i_b,
  output logic [2*WIDTH-1:0] o_acc_next
);

  logic [2*WIDTH-1:0] r_acc;
  logic [2*WIDTH-1:0] r_mcand;
  logic [WIDTH-1:0]   r_mplier;
  logic [2*WIDTH-1:0] w_acc_next;

  // Accumulator value after the current step; the top captures it on the final step.
  always_comb begin
    w_acc_next = r_acc;
    if (r_mplier[0]) w_acc_next = r_acc + r_mcand;
  end

  assign o_acc_next = w_acc_next;

  always_ff @(posedge CLK or negedge CLR_bar) begin
    if (!CLR_bar) begin
      r_acc    <= '0;
      r_mcand  <= '0;
      r_mplier <= '0;
    end else if (i_load) begin
      r_acc    <= '0;
      r_mcand  <= {{WIDTH{1'b0}}, i_a};
      r_mplier <= i_b;
    end else if (i_step) begin
      r_acc    <= w_acc_next;
      r_mcand  <= r_mcand << 1;
      r_mplier <= r_mplier >> 1;
    end
  end

endmodule

// File: rtl/seq_shift_add_multiplier.sv
// Iterative unsigned multiplier, one multiplier bit per clock, with the divider's
// start/ready/done handshake. Holds FSM, step counter and the result registers.
module seq_shift_add_multiplier
  import divider_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic               CLK,
  input  logic               CLR_bar,
  input  logic               start,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               ready,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] product
);

  localparam int unsigned CntW = clog2(WIDTH);
  localparam logic [CntW-1:0] CntLast = CntW'(WIDTH - 1);

  div_state_e         r_state;
  div_state_e         w_state_next;
  logic [CntW-1:0]    r_count;
  logic [CntW-1:0]    w_count_next;
  logic [2*WIDTH-1:0] r_product;
  logic [2*WIDTH-1:0] w_product_next;
  logic               r_done;
  logic               w_done_next;
  logic               w_load;
  logic               w_step;
  logic [2*WIDTH-1:0] w_acc_next;

  mul_shift_add_dp #(
    .WIDTH (WIDTH)
  ) u_dp (
    .CLK        (CLK),
    .CLR_bar    (CLR_bar),
    .i_load     (w_load),
    .i_step     (w_step),
    .i_a        (a),
    .i_b        (b),
    .o_acc_next (w_acc_next)
  );

  always_comb begin
    w_state_next   = r_state;
    w_count_next   = r_count;
    w_product_next = r_product;
    w_done_next    = 1'b0;
    w_load         = 1'b0;
    w_step         = 1'b0;
    ready          = 1'b0;
    busy           = 1'b0;
    case (r_state)
      StIdle: begin
        ready = 1'b1;
        if (start) begin
          w_load       = 1'b1;
          w_count_next = '0;
          w_state_next = StRun;
        end
      end
      StRun: begin
        busy         = 1'b1;
        w_step       = 1'b1;
        w_count_next = r_count + CntW'(1);
        if (r_count == CntLast) begin
          w_product_next = w_acc_next;
          w_done_next    = 1'b1;
          w_state_next   = StDone;
        end
      end
      StDone: begin
        ready = 1'b1;
        // Back-to-back accept keeps throughput at one result per WIDTH+1 cycles.
        if (start) begin
          w_load       = 1'b1;
          w_count_next = '0;
          w_state_next = StRun;
        end else begin
          w_state_next = StIdle;
        end
      end
      default: begin
        w_count_next = '0;
        w_state_next = StIdle;
      end
    endcase
  end

  always_ff @(posedge CLK or negedge CLR_bar) begin
    if (!CLR_bar) begin
      r_state   <= StIdle;
      r_count   <= '0;
      r_product <= '0;
      r_done    <= 1'b0;
    end else begin
      r_state   <= w_state_next;
      r_count   <= w_count_next;
      r_product <= w_product_next;
      r_done    <= w_done_next;
    end
  end

  assign done    = r_done;
  assign product = r_product;

endmodule

// File: tb/tb_seq_shift_add_multiplier.sv
// Self-checking bench for seq_shift_add_multiplier (WIDTH=8) using an expected-product queue.
module tb_seq_shift_add_multiplier;

  localparam int unsigned W = 8;

  logic           CLK = 1'b0;
  logic           CLR_bar;
  logic           start;
  logic [W-1:0]   a;
  logic [W-1:0]   b;
  logic           ready;
  logic           busy;
  logic           done;
  logic [2*W-1:0] product;

  int             n_checks = 0;
  int             n_fail   = 0;
  logic [2*W-1:0] exp_q[$];
  logic [2*W-1:0] prod_hold;

  always #5 CLK = ~CLK;

  seq_shift_add_multiplier #(
    .WIDTH (W)
  ) dut (
    .CLK     (CLK),
    .CLR_bar (CLR_bar),
    .start   (start),
    .a       (a),
    .b       (b),
    .ready   (ready),
    .busy    (busy),
    .done    (done),
    .product (product)
  );

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  // Drive one accepted start and record its expected product.
  task automatic accept(input logic [W-1:0] ta, input logic [W-1:0] tb_);
    start = 1'b1;
    a     = ta;
    b     = tb_;
    n_checks++;
    if (ready !== 1'b1) begin
      n_fail++;
      $display("FAIL accept_ready: ready=%b required 1", ready);
    end
    tick();
    start = 1'b0;
    exp_q.push_back((2*W)'(ta) * (2*W)'(tb_));
  endtask

  // Wait (bounded) for done; check latency, result, and RUN-phase outputs.
  task automatic finish_op(input bit scramble);
    int             lat;
    bit             stable;
    bit             run_ok;
    logic [2*W-1:0] exp;
    lat    = 0;
    stable = 1'b1;
    run_ok = 1'b1;
    while (done !== 1'b1 && lat < int'(4 * W)) begin
      if (product !== prod_hold) stable = 1'b0;
      if (busy !== 1'b1 || ready !== 1'b0) run_ok = 1'b0;
      if (scramble) begin
        a = W'($urandom);
        b = W'($urandom);
      end
      tick();
      lat++;
    end
    n_checks++;
    if (lat != int'(W)) begin
      n_fail++;
      $display("FAIL latency: done after %0d edges, required %0d", lat, W);
    end
    exp = '0;
    if (exp_q.size() != 0) exp = exp_q.pop_front();
    n_checks++;
    if (product !== exp) begin
      n_fail++;
      $display("FAIL product: got %0d required %0d", product, exp);
    end
    n_checks++;
    if (!stable) begin
      n_fail++;
      $display("FAIL product_stable: changed before done, required held %0d", prod_hold);
    end
    n_checks++;
    if (!run_ok || busy !== 1'b0 || ready !== 1'b1) begin
      n_fail++;
      $display("FAIL run_flags: run_ok=%b busy=%b ready=%b at done, required 1/0/1",
               run_ok, busy, ready);
    end
    prod_hold = exp;
  endtask

  task automatic test_reset();
    CLR_bar = 1'b0;
    start   = 1'b0;
    a       = '0;
    b       = '0;
    #1;
    n_checks++;
    if (ready !== 1'b1 || busy !== 1'b0 || done !== 1'b0 || product !== '0) begin
      n_fail++;
      $display("FAIL reset_state: ready=%b busy=%b done=%b product=%0d required 1/0/0/0",
               ready, busy, done, product);
    end
    repeat (2) tick();
    CLR_bar = 1'b1;
    tick();
  endtask

  task automatic test_basic();
    accept(8'd13, 8'd11);
    finish_op(1'b0);
  endtask

  task automatic test_extremes();
    accept(8'd255, 8'd255);
    finish_op(1'b0);
    tick();
    n_checks++;
    if (done !== 1'b0 || ready !== 1'b1 || busy !== 1'b0 || product !== 16'hFE01) begin
      n_fail++;
      $display("FAIL idle_hold: done=%b ready=%b busy=%b product=%0h required 0/1/0/fe01",
               done, ready, busy, product);
    end
    accept(8'd0, 8'd200);
    finish_op(1'b0);
  endtask

  task automatic test_start_ignored();
    accept(8'd20, 8'd30);
    start = 1'b1;
    a     = 8'd99;
    b     = 8'd77;
    finish_op(1'b0);
    accept(8'd3, 8'd5);
    n_checks++;
    if (done !== 1'b0 || busy !== 1'b1) begin
      n_fail++;
      $display("FAIL rearm_from_done: done=%b busy=%b required 0/1", done, busy);
    end
    finish_op(1'b0);
  endtask

  task automatic test_reset_mid_run();
    bit quiet;
    accept(8'd100, 8'd200);
    repeat (4) tick();
    CLR_bar = 1'b0;
    #1;
    n_checks++;
    if (ready !== 1'b1 || busy !== 1'b0 || done !== 1'b0 || product !== '0) begin
      n_fail++;
      $display("FAIL reset_mid_run: ready=%b busy=%b done=%b product=%0d required 1/0/0/0",
               ready, busy, done, product);
    end
    tick();
    tick();
    CLR_bar = 1'b1;
    exp_q.delete();
    prod_hold = '0;
    quiet = 1'b1;
    repeat (2 * W) begin
      tick();
      if (done !== 1'b0 || product !== '0 || ready !== 1'b1) quiet = 1'b0;
    end
    n_checks++;
    if (!quiet) begin
      n_fail++;
      $display("FAIL no_done_after_reset: saw activity (done=%b product=%0d), required idle",
               done, product);
    end
    accept(8'd7, 8'd9);
    finish_op(1'b0);
  endtask

  task automatic test_operand_change();
    accept(8'd201, 8'd57);
    finish_op(1'b1);
    accept(8'd170, 8'd85);
    finish_op(1'b1);
  endtask

  task automatic test_random();
    int  gap;
    bit  idle_ok;
    for (int i = 0; i < 1000; i++) begin
      gap     = int'($urandom_range(0, 2));
      idle_ok = 1'b1;
      for (int g = 0; g < gap; g++) begin
        tick();
        if (done !== 1'b0 || product !== prod_hold) idle_ok = 1'b0;
      end
      n_checks++;
      if (!idle_ok) begin
        n_fail++;
        $display("FAIL idle_stable op %0d: done=%b product=%0d required 0/%0d",
                 i, done, product, prod_hold);
      end
      accept(W'($urandom), W'($urandom));
      finish_op(i[0]);
    end
  endtask

  initial begin
    prod_hold = '0;
    test_reset();
    test_basic();
    test_extremes();
    test_start_ignored();
    test_reset_mid_run();
    test_operand_change();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule
